clk_en_gen_seq: RTL and testbench



---
 rtl/clk_en_gen_pkg.sv | 31 +++
 rtl/clk_en_gen_seq_chan.sv | 119 +++++++++++
 rtl/clk_en_gen_seq.sv | 147 ++++++++++++++
 tb/tb_clk_en_gen_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg
//   Shared types and helpers for the clk_en_gen_seq clock-enable generator.
//   - fsm_state_t : sequencer states
//   - idx_w()     : index width for a count of items (never below 1)
//   - clamp_div() : divide ratio 0 is treated as 1
//   - clamp_phase(): phase is limited to div-1 of the (clamped) divide ratio
package clk_en_gen_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      RUN    = 2'd1,
      RECONF = 2'd2
   } fsm_state_t;

   function automatic int unsigned idx_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned clamp_div(int unsigned d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int unsigned clamp_phase(int unsigned p, int unsigned d);
      int unsigned dc;
      dc = clamp_div(d);
      return (p >= dc) ? dc - 1 : p;
   endfunction

endpackage

// File: rtl/clk_en_gen_seq_chan.sv
// clk_en_gen_chan
//   One clock-enable channel: free-running divide counter, strobe compare,
//   pending-reload register for a requested ratio change, and a relock
//   down-counter that holds chan_locked low for one full new period.
// Ports:
//   refclk, rst        clock, async active-high reset
//   start              one-cycle pulse: phase-aligned start of all channels
//   load_req           one-cycle pulse: capture new_div/new_phase as pending
//   new_div, new_phase requested ratio/phase (clamped on capture)
//   clk_en             registered strobe, high while cnt == phase
//   chan_locked        channel running on its current configuration
module clk_en_gen_chan
   import clk_en_gen_pkg::*;
#(
   parameter int               DIV_W     = 8,
   parameter logic [DIV_W-1:0] DIV_RST   = 8'd2,
   parameter logic [DIV_W-1:0] PHASE_RST = 8'd0
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             start,
   input  logic             load_req,
   input  logic [DIV_W-1:0] new_div,
   input  logic [DIV_W-1:0] new_phase,
   output logic             clk_en,
   output logic             chan_locked
);

   localparam logic [DIV_W-1:0] DIV_R = DIV_W'(clamp_div(32'(DIV_RST)));
   localparam logic [DIV_W-1:0] PH_R  = DIV_W'(clamp_phase(32'(PHASE_RST), 32'(DIV_R)));

   logic             active_q, active_d;
   logic             pend_q, pend_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] phase_q, phase_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic [DIV_W-1:0] pend_phase_q, pend_phase_d;
   logic [DIV_W-1:0] relock_q, relock_d;
   logic             clk_en_d, locked_d;
   logic             wrap;

   assign wrap = active_q && (cnt_q == div_q - DIV_W'(1));

   always_comb begin
      active_d     = active_q;
      pend_d       = pend_q;
      div_d        = div_q;
      phase_d      = phase_q;
      cnt_d        = cnt_q;
      pend_div_d   = pend_div_q;
      pend_phase_d = pend_phase_q;
      relock_d     = relock_q;
      locked_d     = chan_locked;
      clk_en_d     = 1'b0;

      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         pend_d   = 1'b0;
         relock_d = '0;
         locked_d = 1'b1;
         clk_en_d = (phase_q == '0);
      end else if (active_q) begin
         cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);

         if (relock_q == DIV_W'(1))
            locked_d = 1'b1;
         if (relock_q != '0)
            relock_d = relock_q - DIV_W'(1);

         // A pending change only takes effect at the old period boundary so
         // the last old period is never truncated.
         if (pend_q && wrap) begin
            div_d    = pend_div_q;
            phase_d  = pend_phase_q;
            pend_d   = 1'b0;
            relock_d = pend_div_q;
         end

         if (load_req) begin
            pend_d       = 1'b1;
            pend_div_d   = DIV_W'(clamp_div(32'(new_div)));
            pend_phase_d = DIV_W'(clamp_phase(32'(new_phase), 32'(new_div)));
            locked_d     = 1'b0;
         end

         // Strobes are muted while a change is waiting for the wrap.
         clk_en_d = !pend_d && (cnt_d == phase_d);
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         active_q     <= 1'b0;
         pend_q       <= 1'b0;
         div_q        <= DIV_R;
         phase_q      <= PH_R;
         cnt_q        <= '0;
         pend_div_q   <= DIV_R;
         pend_phase_q <= PH_R;
         relock_q     <= '0;
         clk_en       <= 1'b0;
         chan_locked  <= 1'b0;
      end else begin
         active_q     <= active_d;
         pend_q       <= pend_d;
         div_q        <= div_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         pend_div_q   <= pend_div_d;
         pend_phase_q <= pend_phase_d;
         relock_q     <= relock_d;
         clk_en       <= clk_en_d;
         chan_locked  <= locked_d;
      end
   end

endmodule

// File: rtl/clk_en_gen_seq.sv
// clk_en_gen_seq
//   Multi-channel clock-enable generator with lock sequencing. After reset it
//   holds every channel quiet for LOCK_CYCLES refclk cycles, then starts all
//   channels phase-aligned. Channels can be re-programmed one at a time over a
//   valid/ready handshake; the sequencer waits for the target channel to relock
//   before taking another request.
// Build option:
//   CLK_EN_GEN_CFG_ERR_EN  adds cfg_err; requests with cfg_chan >= N_CH or
//                          cfg_div == 0 are rejected with a one-cycle cfg_err.
// Ports:
//   refclk       reference clock (sole clock)
//   rst          async active-high reset
//   cfg_valid    reconfiguration request
//   cfg_ready    request can be accepted (RUN only)
//   cfg_chan     target channel
//   cfg_div      new divide ratio
//   cfg_phase    new phase offset
//   clk_en       per-channel one-cycle enable strobes
//   chan_locked  per-channel stable indication
//   locked       registered: not settling and all channels stable
//   cfg_err      (option) rejected request pulse
//
// state  | meaning
// SETTLE | counting out the lock interval, all strobes held low
// RUN    | channels running, cfg_ready high
// RECONF | waiting for the target channel to relock
module clk_en_gen_seq
   import clk_en_gen_pkg::*;
#(
   parameter int                    N_CH        = 2,
   parameter int                    DIV_W       = 8,
   parameter int                    LOCK_CYCLES = 64,
   parameter logic [N_CH*DIV_W-1:0] DIV_INIT    = {8'd3, 8'd2},
   parameter logic [N_CH*DIV_W-1:0] PHASE_INIT  = {8'd0, 8'd0}
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [idx_w(N_CH)-1:0]  cfg_chan,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [DIV_W-1:0]        cfg_phase,
   output logic [N_CH-1:0]         clk_en,
   output logic [N_CH-1:0]         chan_locked,
   output logic                    locked
`ifdef CLK_EN_GEN_CFG_ERR_EN
   ,
   output logic                    cfg_err
`endif
);

   localparam int CHW      = idx_w(N_CH);
   localparam int SETTLE_W = idx_w(LOCK_CYCLES);

   fsm_state_t          state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [CHW-1:0]      tgt_q, tgt_d;
   logic                start;
   logic                cfg_ok;
   logic                accept;
   logic [N_CH-1:0]     load_req;

`ifdef CLK_EN_GEN_CFG_ERR_EN
   assign cfg_ok = (32'(cfg_chan) < N_CH) && (cfg_div != '0);
`else
   // Out-of-range channels are taken but address no channel, so the
   // sequencer simply stays in RUN.
   assign cfg_ok = (32'(cfg_chan) < N_CH);
`endif

   assign accept = cfg_ready && cfg_valid && cfg_ok;

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      tgt_d     = tgt_q;
      start     = 1'b0;
      cfg_ready = (state_q == RUN);

      unique case (state_q)
         SETTLE: begin
            if (settle_q == SETTLE_W'(LOCK_CYCLES - 1)) begin
               state_d = RUN;
               start   = 1'b1;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end
         RUN: begin
            if (accept) begin
               state_d = RECONF;
               tgt_d   = cfg_chan;
            end
         end
         RECONF: begin
            // The target dropped chan_locked on entry, so a high value here
            // means its relock period has completed.
            if (chan_locked[tgt_q])
               state_d = RUN;
         end
         default: state_d = SETTLE;
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q  <= SETTLE;
         settle_q <= '0;
         tgt_q    <= '0;
         locked   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         tgt_q    <= tgt_d;
         locked   <= (state_q != SETTLE) && (&chan_locked);
      end
   end

`ifdef CLK_EN_GEN_CFG_ERR_EN
   always_ff @(posedge refclk or posedge rst) begin
      if (rst)
         cfg_err <= 1'b0;
      else
         cfg_err <= cfg_ready && cfg_valid && !cfg_ok;
   end
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      assign load_req[i] = accept && (cfg_chan == CHW'(i));

      clk_en_gen_chan #(
         .DIV_W     (DIV_W),
         .DIV_RST   (DIV_INIT[i*DIV_W +: DIV_W]),
         .PHASE_RST (PHASE_INIT[i*DIV_W +: DIV_W])
      ) u_chan (
         .refclk      (refclk),
         .rst         (rst),
         .start       (start),
         .load_req    (load_req[i]),
         .new_div     (cfg_div),
         .new_phase   (cfg_phase),
         .clk_en      (clk_en[i]),
         .chan_locked (chan_locked[i])
      );
   end

endmodule

// File: tb/tb_clk_en_gen_seq.sv
// tb_clk_en_gen_seq
//   Directed and random reconfiguration of clk_en_gen_seq, compared every
//   cycle against a period/phase arithmetic model: each channel is described
//   by (epoch start, div, phase), a change takes effect one cycle after the
//   first old-period boundary following the request, and lock/ready are
//   low over closed cycle windows derived from that boundary.
module tb_clk_en_gen_seq;

   localparam int N_CH  = 2;
   localparam int DIV_W = 8;
   localparam int LOCK  = 64;
   localparam int CHW   = 1;

   logic              refclk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CHW-1:0]    cfg_chan = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic [DIV_W-1:0]  cfg_phase = '0;
   logic [N_CH-1:0]   clk_en;
   logic [N_CH-1:0]   chan_locked;
   logic              locked;
`ifdef CLK_EN_GEN_CFG_ERR_EN
   logic              cfg_err;
`endif

   always #5 refclk = ~refclk;

   clk_en_gen_seq #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .LOCK_CYCLES (LOCK),
      .DIV_INIT    ({8'd3, 8'd2}),
      .PHASE_INIT  ({8'd0, 8'd0})
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_chan    (cfg_chan),
      .cfg_div     (cfg_div),
      .cfg_phase   (cfg_phase),
      .clk_en      (clk_en),
      .chan_locked (chan_locked),
      .locked      (locked)
`ifdef CLK_EN_GEN_CFG_ERR_EN
      ,
      .cfg_err     (cfg_err)
`endif
   );

   int init_d [N_CH] = '{2, 3};
   int init_p [N_CH] = '{0, 0};

   int m_s  [N_CH];
   int m_d  [N_CH];
   int m_p  [N_CH];
   int m_lo [N_CH];
   int m_hi [N_CH];
   int b_lo, b_hi;
   bit prev_all;
   bit err_exp;
   int t;
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_s[i]  = LOCK;
         m_d[i]  = init_d[i];
         m_p[i]  = init_p[i];
         m_lo[i] = 1;
         m_hi[i] = 0;
      end
      b_lo     = 1;
      b_hi     = 0;
      prev_all = 1'b0;
      err_exp  = 1'b0;
      t        = 0;
   endtask

   task automatic handshake(input int c, input int dv, input int ph);
      int nd, np, r, w;
      nd = (dv == 0) ? 1 : dv;
      np = (ph >= nd) ? nd - 1 : ph;
      r  = (t + 1 - m_s[c]) % m_d[c];
      w  = t + 1 + (m_d[c] - 1 - r);
      m_lo[c] = t + 1;
      m_hi[c] = w + nd;
      b_lo    = t + 1;
      b_hi    = w + 1 + nd;
      m_s[c]  = w + 1;
      m_d[c]  = nd;
      m_p[c]  = np;
   endtask

   task automatic cycle(input bit v, input int ch, input int dv, input int ph, output bit acc);
      logic [N_CH-1:0] e_en, e_cl;
      logic            e_rdy;
      for (int i = 0; i < N_CH; i++) begin
         e_en[i] = (t >= m_s[i]) && (((t - m_s[i]) % m_d[i]) == m_p[i]);
         e_cl[i] = (t >= LOCK) && !((t >= m_lo[i]) && (t <= m_hi[i]));
      end
      e_rdy = (t >= LOCK) && !((t >= b_lo) && (t <= b_hi));
      chk("clk_en", 32'(clk_en), 32'(e_en));
      chk("chan_locked", 32'(chan_locked), 32'(e_cl));
      chk("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
      chk("locked", 32'(locked), 32'(prev_all));
`ifdef CLK_EN_GEN_CFG_ERR_EN
      chk("cfg_err", 32'(cfg_err), 32'(err_exp));
`endif
      cfg_valid = v;
      cfg_chan  = CHW'(ch);
      cfg_div   = DIV_W'(dv);
      cfg_phase = DIV_W'(ph);
      acc       = e_rdy && v;
      err_exp   = 1'b0;
      if (acc) begin
`ifdef CLK_EN_GEN_CFG_ERR_EN
         if (dv == 0 || ch >= N_CH) begin
            err_exp = 1'b1;
            acc     = 1'b0;
         end else
`endif
         handshake(ch, dv, ph);
      end
      prev_all = (t >= LOCK) && (&e_cl);
      @(negedge refclk);
      t++;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 0, acc);
   endtask

   // Holds cfg_valid with the given request until the model accepts it.
   task automatic request(input int ch, input int dv, input int ph);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) cycle(1'b1, ch, dv, ph, acc);
      if (!acc) chk("request_accept", 32'(0), 32'(1));
   endtask

   initial begin
      bit acc;

      model_reset();
      rst = 1'b1;
      repeat (3) @(negedge refclk);
      rst = 1'b0;

      // Lock interval and default strobe pattern.
      while (t < 80) cycle(1'b0, 0, 0, 0, acc);

      // Mid-period change of channel 1 to div 5 / phase 2.
      request(1, 5, 2);
      idle(30);

      // Back-to-back requests with cfg_valid held high throughout.
      request(0, 4, 1);
      request(1, 3, 0);
      idle(20);

      // Boundary values: div 1, phase clamp, div 0.
      request(0, 1, 0);
      idle(12);
      request(1, 4, 9);
      idle(20);
      request(0, 0, 0);
      idle(12);
      request(0, 2, 1);
      idle(10);

      // Random requests.
      for (int k = 0; k < 600; k++) begin
         cycle(($urandom_range(0, 5) == 0), int'($urandom_range(0, N_CH - 1)),
               int'($urandom_range(0, 9)), int'($urandom_range(0, 11)), acc);
      end
      idle(30);

      // Reset while channel 1 is waiting on a pending change.
      request(1, 7, 4);
      idle(2);
      rst = 1'b1;
      cfg_valid = 1'b0;
      #1;
      chk("rst_clk_en", 32'(clk_en), 32'(0));
      chk("rst_chan_locked", 32'(chan_locked), 32'(0));
      chk("rst_locked", 32'(locked), 32'(0));
      chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
      repeat (2) @(negedge refclk);
      rst = 1'b0;
      model_reset();
      idle(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
